dmem_arbiter: RTL and testbench

- Two-requester arbiter for the shared single-port data memory. The memory has a registered read, so data is valid one cycle after the access.
- Port A is the CPU pipeline MEM stage and has priority. Port B is a DMA/boot-loader master.
- A starvation counter bounds how long B can wait.
- B is blocked from writing peripheral space (address[31:28]==4'h4).

---
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter.sv | 75 +++++++
 tb/tb_dmem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-return bundle between the two data-memory masters, the
// arbiter and the single-port data memory.
interface dmem_arbiter_if;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [31:0] mem_Address, mem_Write_data, mem_Read_data;
    logic        mem_MemRead, mem_MemWrite;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_Read_data,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_Address, mem_Write_data, mem_MemRead, mem_MemWrite
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_Read_data,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_Address, mem_Write_data, mem_MemRead, mem_MemWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared data memory: A (CPU MEM stage) has priority,
// B (DMA/boot loader) is forced through after STARVE_MAX lost contests.
module dmem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    owner_t           rd_owner;
    logic             b_err_q;
    logic             force_b, a_gnt, b_gnt, b_blk;

    assign force_b = (STARVE_MAX != 0) && (starve_cnt == SMAX);
    assign a_gnt   = bus.a_req && !(bus.b_req && force_b);
    assign b_gnt   = bus.b_req && (!bus.a_req || force_b);
    // B writes into peripheral space retire without reaching the memory.
    assign b_blk   = b_gnt && bus.b_we && (bus.b_addr[31:28] == 4'h4);

    assign bus.a_gnt = a_gnt;
    assign bus.b_gnt = b_gnt;
    assign bus.b_err = b_err_q;

    always_comb begin
        bus.mem_Address    = 32'h0;
        bus.mem_Write_data = 32'h0;
        bus.mem_MemRead    = 1'b0;
        bus.mem_MemWrite   = 1'b0;
        if (a_gnt) begin
            bus.mem_Address    = bus.a_addr;
            bus.mem_Write_data = bus.a_wdata;
            bus.mem_MemRead    = !bus.a_we;
            bus.mem_MemWrite   = bus.a_we;
        end else if (b_gnt) begin
            bus.mem_Address    = bus.b_addr;
            bus.mem_Write_data = bus.b_wdata;
            bus.mem_MemRead    = !bus.b_we;
            bus.mem_MemWrite   = bus.b_we && !b_blk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            rd_owner   <= OWN_NONE;
            b_err_q    <= 1'b0;
        end else begin
            b_err_q <= b_blk;

            if (b_gnt || !bus.b_req)
                starve_cnt <= '0;
            else if (a_gnt && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 1'b1;

            if (a_gnt && !bus.a_we)
                rd_owner <= OWN_A;
            else if (b_gnt && !bus.b_we)
                rd_owner <= OWN_B;
            else
                rd_owner <= OWN_NONE;
        end
    end

    // Memory read data is registered, so it lines up with the owner register.
    assign bus.a_rvalid = (rd_owner == OWN_A);
    assign bus.b_rvalid = (rd_owner == OWN_B);
    assign bus.a_rdata  = bus.a_rvalid ? bus.mem_Read_data : 32'h0;
    assign bus.b_rdata  = bus.b_rvalid ? bus.mem_Read_data : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters (STARVE_MAX 4, 0, 1) each with a small
// registered-read memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if if4 ();
    dmem_arbiter_if if0 ();
    dmem_arbiter_if if1 ();

    dmem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    dmem_arbiter #(.STARVE_MAX(0), .CNT_W(3)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    dmem_arbiter #(.STARVE_MAX(1), .CNT_W(3)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    function automatic logic [31:0] memf(input logic [31:0] addr);
        return (addr == 32'h10) ? 32'hDEADBEEF : (addr ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) begin
        if4.mem_Read_data <= if4.mem_MemRead ? memf(if4.mem_Address) : 32'h0;
        if0.mem_Read_data <= if0.mem_MemRead ? memf(if0.mem_Address) : 32'h0;
        if1.mem_Read_data <= if1.mem_MemRead ? memf(if1.mem_Address) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_b [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        {if4.a_req, if4.a_we, if4.b_req, if4.b_we} = '0;
        {if0.a_req, if0.a_we, if0.b_req, if0.b_we} = '0;
        {if1.a_req, if1.a_we, if1.b_req, if1.b_we} = '0;
        {if4.a_addr, if4.a_wdata, if4.b_addr, if4.b_wdata} = '0;
        {if0.a_addr, if0.a_wdata, if0.b_addr, if0.b_wdata} = '0;
        {if1.a_addr, if1.a_wdata, if1.b_addr, if1.b_wdata} = '0;
        #2 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_a_rvalid", 32'(if4.a_rvalid), 0);
        chk("rst_b_rvalid", 32'(if4.b_rvalid), 0);
        chk("rst_b_err", 32'(if4.b_err), 0);
        chk("rst_a_rdata", if4.a_rdata, 0);
        chk("rst_b_rdata", if4.b_rdata, 0);
        chk("rst_starve", 32'(dut4.starve_cnt), 0);
        chk("rst_mem_addr", if4.mem_Address, 0);
        tick();
        reset = 1'b1;

        // A-only read
        if4.a_req = 1; if4.a_we = 0; if4.a_addr = 32'h10;
        @(negedge clk);
        chk("a_rd_gnt", 32'(if4.a_gnt), 1);
        chk("a_rd_bgnt", 32'(if4.b_gnt), 0);
        chk("a_rd_memread", 32'(if4.mem_MemRead), 1);
        chk("a_rd_addr", if4.mem_Address, 32'h10);
        tick();
        if4.a_req = 0;
        @(negedge clk);
        chk("a_rd_rvalid", 32'(if4.a_rvalid), 1);
        chk("a_rd_rdata", if4.a_rdata, 32'hDEADBEEF);
        chk("a_rd_b_rvalid", 32'(if4.b_rvalid), 0);
        chk("a_rd_idle_addr", if4.mem_Address, 0);
        tick();
        @(negedge clk);
        chk("a_rd_pulse_end", 32'(if4.a_rvalid), 0);

        // contention, STARVE_MAX=4
        tick();
        if4.a_req = 1; if4.a_addr = 32'h100;
        if4.b_req = 1; if4.b_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("seq_b_gnt[%0d]", i), 32'(if4.b_gnt), 32'(exp_b[i]));
            chk($sformatf("seq_a_gnt[%0d]", i), 32'(if4.a_gnt), 32'(!exp_b[i]));
            chk($sformatf("seq_cnt[%0d]", i), 32'(dut4.starve_cnt), 32'(i % 5));
            tick();
        end
        if4.a_req = 0; if4.b_req = 0;
        tick();

        // B peripheral write blocked, then normal write, then peripheral read
        if4.b_req = 1; if4.b_we = 1; if4.b_addr = 32'h4000000C; if4.b_wdata = 32'h55;
        @(negedge clk);
        chk("blk_b_gnt", 32'(if4.b_gnt), 1);
        chk("blk_memwrite", 32'(if4.mem_MemWrite), 0);
        chk("blk_err_before", 32'(if4.b_err), 0);
        tick();
        if4.b_addr = 32'h20;
        @(negedge clk);
        chk("blk_err_pulse", 32'(if4.b_err), 1);
        chk("wr_b_gnt", 32'(if4.b_gnt), 1);
        chk("wr_memwrite", 32'(if4.mem_MemWrite), 1);
        chk("wr_wdata", if4.mem_Write_data, 32'h55);
        chk("wr_addr", if4.mem_Address, 32'h20);
        tick();
        if4.b_we = 0; if4.b_addr = 32'h40000000;
        @(negedge clk);
        chk("wr_no_err", 32'(if4.b_err), 0);
        chk("wr_no_rvalid", 32'(if4.b_rvalid), 0);
        chk("prd_memread", 32'(if4.mem_MemRead), 1);
        tick();
        if4.b_req = 0;
        @(negedge clk);
        chk("prd_no_err", 32'(if4.b_err), 0);
        chk("prd_rvalid", 32'(if4.b_rvalid), 1);
        chk("prd_rdata", if4.b_rdata, 32'hE5A50000);
        chk("prd_a_rvalid", 32'(if4.a_rvalid), 0);
        tick();

        // reset during a pending read return
        if4.a_req = 1; if4.a_we = 0; if4.a_addr = 32'h10;
        @(negedge clk);
        chk("mr_a_gnt", 32'(if4.a_gnt), 1);
        tick();
        reset = 1'b0; if4.a_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("mr_rvalid[%0d]", i), 32'(if4.a_rvalid), 0);
            chk($sformatf("mr_rdata[%0d]", i), if4.a_rdata, 0);
            chk($sformatf("mr_gnt[%0d]", i), 32'({if4.a_gnt, if4.b_gnt}), 0);
            chk($sformatf("mr_mem[%0d]", i), 32'({if4.mem_MemRead, if4.mem_MemWrite}), 0);
            chk($sformatf("mr_err[%0d]", i), 32'(if4.b_err), 0);
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mr_post_rvalid", 32'(if4.a_rvalid), 0);
        chk("mr_post_cnt", 32'(dut4.starve_cnt), 0);
        tick();
        if4.a_req = 1; if4.b_req = 1; if4.a_addr = 32'h100; if4.b_addr = 32'h200;
        @(negedge clk);
        chk("mr_first_a", 32'(if4.a_gnt), 1);
        chk("mr_first_b", 32'(if4.b_gnt), 0);
        tick();
        if4.a_req = 0; if4.b_req = 0;

        // STARVE_MAX=0: strict A priority
        if0.a_req = 1; if0.b_req = 1; if0.a_addr = 32'h100; if0.b_addr = 32'h200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("strict_b_gnt[%0d]", i), 32'(if0.b_gnt), 0);
            chk($sformatf("strict_cnt[%0d]", i), 32'(dut0.starve_cnt), 0);
            tick();
        end
        if0.a_req = 0; if0.b_req = 0;

        // STARVE_MAX=1: alternating reads, back-to-back rvalid pulses
        if1.a_req = 1; if1.b_req = 1; if1.a_addr = 32'h300; if1.b_addr = 32'h404;
        @(negedge clk);
        chk("alt_first_a", 32'(if1.a_gnt), 1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                chk($sformatf("alt_a_rvalid[%0d]", k), 32'(if1.a_rvalid), 1);
                chk($sformatf("alt_b_rvalid[%0d]", k), 32'(if1.b_rvalid), 0);
                chk($sformatf("alt_a_rdata[%0d]", k), if1.a_rdata, 32'hA5A50300);
                chk($sformatf("alt_b_rdata[%0d]", k), if1.b_rdata, 0);
            end else begin
                chk($sformatf("alt_a_rvalid[%0d]", k), 32'(if1.a_rvalid), 0);
                chk($sformatf("alt_b_rvalid[%0d]", k), 32'(if1.b_rvalid), 1);
                chk($sformatf("alt_b_rdata[%0d]", k), if1.b_rdata, 32'hA5A50404);
                chk($sformatf("alt_a_rdata[%0d]", k), if1.a_rdata, 0);
            end
            tick();
        end
        if1.a_req = 0; if1.b_req = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
